// File: rtl/dff_err_pkg.sv
// Shared types and helpers for the DFF error-count serializer.
package dff_err_pkg;

   // Frame phases; data_out always carries the bit belonging to the current state
   typedef enum logic [1:0] {
      StIdle,
      StHdr,
      StData,
      StPar
   } state_e;

   localparam logic [7:0] HDR_DEFAULT = 8'hA5;

   // Ceiling log2; clog2(1) = 0
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with a rising-edge pulse on the synchronised level.
module sync_edge_det #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic prev_q, prev_d;

   // Shift the asynchronous level through the sync chain and keep one cycle of history
   always_comb begin
      s1_d   = d_i;
      s2_d   = s1_q;
      prev_d = s2_q;
   end

   // Sync/history flops; reset value chosen so a level held across reset is not an edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q   <= RESET_VAL;
         s2_q   <= RESET_VAL;
         prev_q <= RESET_VAL;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
      end
   end

   assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/dff_err_serializer.sv
// Snapshots NUM_CH error counters and shifts them out as header | data | even parity.
module dff_err_serializer
   import dff_err_pkg::*;
#(
   parameter int unsigned      NUM_CH     = 14,
   parameter int unsigned      CNT_W      = 32,
   parameter int unsigned      HDR_W      = 8,
   parameter logic [HDR_W-1:0] HDR        = HDR_W'(HDR_DEFAULT),
   parameter bit               MSB_FIRST  = 1'b0,
   parameter bit               CONTINUOUS = 1'b1
) (
   input  logic                    data_clk,
   input  logic                    reset,
   input  logic                    save_data,
   input  logic [NUM_CH*CNT_W-1:0] err_cnt,
   output logic                    data_out,
   output logic                    frame_valid,
   output logic                    frame_start,
   output logic                    busy,
   output logic                    overrun
);

   localparam int unsigned TOT_W = NUM_CH * CNT_W;
   localparam int unsigned MAX_W = (HDR_W > CNT_W) ? HDR_W : CNT_W;
   localparam int unsigned BIT_W = (clog2(MAX_W) > 0) ? clog2(MAX_W) : 1;
   localparam int unsigned CH_W  = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1;

   state_e           state_q, state_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [TOT_W-1:0] snap_q, snap_d;
   logic             pend_q, pend_d;
   logic             ovr_q, ovr_d;
   logic             par_q, par_d;
   logic             dout_q, dout_d;
   logic             fv_q, fv_d;
   logic             fs_q, fs_d;
   logic             rise;

   sync_edge_det #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk_i (data_clk),
      .rst_ni(reset),
      .d_i   (save_data),
      .rise_o(rise)
   );

   // Phase sequencing, snapshot capture and request/overrun bookkeeping
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      ch_d    = ch_q;
      snap_d  = snap_q;
      pend_d  = pend_q;
      ovr_d   = ovr_q;
      unique case (state_q)
         StIdle: begin
            if (rise) begin
               snap_d  = err_cnt;
               state_d = StHdr;
               bit_d   = '0;
               ch_d    = '0;
            end
         end
         StHdr: begin
            if (bit_q == BIT_W'(HDR_W - 1)) begin
               state_d = StData;
               bit_d   = '0;
               ch_d    = '0;
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
         StData: begin
            if (bit_q == BIT_W'(CNT_W - 1)) begin
               bit_d = '0;
               if (ch_q == CH_W'(NUM_CH - 1)) begin
                  ch_d    = '0;
                  state_d = StPar;
               end else begin
                  ch_d = ch_q + 1'b1;
               end
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
         StPar: begin
            if (CONTINUOUS) begin
               state_d = StHdr;
               bit_d   = '0;
               ch_d    = '0;
               // A rise landing in the parity cycle is served by this same re-snapshot
               if (pend_q || rise) begin
                  snap_d = err_cnt;
                  pend_d = 1'b0;
               end
            end else begin
               state_d = StIdle;
            end
         end
      endcase
      // Requests arriving while a frame is on the wire
      if (state_q != StIdle && rise) begin
         if (!CONTINUOUS || pend_q) begin
            ovr_d = 1'b1;
         end else if (state_q != StPar) begin
            pend_d = 1'b1;
         end
      end
   end

   // Channel view of the next snapshot for bit selection
   logic [CNT_W-1:0] ch_arr [NUM_CH];
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_arr[gi] = snap_d[gi*CNT_W +: CNT_W];
   end

   logic [MAX_W-1:0] hdr_pad;
   logic [MAX_W-1:0] chan_pad;
   logic [BIT_W-1:0] pos;

   // Pick the bit for the next cycle and fold data bits into the running parity
   always_comb begin
      hdr_pad  = MAX_W'(HDR);
      chan_pad = MAX_W'(ch_arr[ch_d]);
      pos      = MSB_FIRST ? (BIT_W'(CNT_W - 1) - bit_d) : bit_d;
      dout_d   = 1'b0;
      par_d    = par_q;
      unique case (state_d)
         StIdle: par_d = 1'b0;
         StHdr: begin
            dout_d = hdr_pad[BIT_W'(HDR_W - 1) - bit_d];
            par_d  = 1'b0;
         end
         StData: begin
            dout_d = chan_pad[pos];
            par_d  = par_q ^ dout_d;
         end
         StPar: dout_d = par_q;
      endcase
      fv_d = (state_d != StIdle);
      fs_d = (state_d == StHdr) && (bit_d == '0);
   end

   // State, snapshot and registered outputs
   always_ff @(posedge data_clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         bit_q   <= '0;
         ch_q    <= '0;
         snap_q  <= '0;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
         par_q   <= 1'b0;
         dout_q  <= 1'b0;
         fv_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         ch_q    <= ch_d;
         snap_q  <= snap_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         par_q   <= par_d;
         dout_q  <= dout_d;
         fv_q    <= fv_d;
         fs_q    <= fs_d;
      end
   end

   assign data_out    = dout_q;
   assign frame_valid = fv_q;
   assign frame_start = fs_q;
   assign busy        = fv_q;
   assign overrun     = ovr_q;

endmodule
